// File: rtl/bfn_predict_engine.sv
// Perceptron-style branch direction predictor: folds NUM_W signed 3-bit weights
// against a snapshot of global history, W_PER_CYC terms per cycle.
module bfn_predict_engine #(
  parameter int NUM_W     = 16,
  parameter int W_PER_CYC = 4,
  parameter int THETA     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_pc,
  input  logic [1:0]           req_status,
  input  logic [1:0]           req_bias,
  input  logic [3*NUM_W-1:0]   req_weight,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_taken,
  output logic [7:0]           resp_sum,
  output logic                 resp_confident,
  output logic [31:0]          resp_pc,
  input  logic                 hist_valid,
  input  logic                 hist_dir,
  input  logic                 hist_restore,
  input  logic [NUM_W-1:0]     hist_restore_val,
  input  logic                 flush,
  output logic [NUM_W-1:0]     ghr,
  output logic [1:0]           dbg_state
);

  localparam int NUM_BEATS = NUM_W / W_PER_CYC;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic signed [8:0] THETA_S = 9'(THETA);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and flush overrides any transfer.
  state_e               state_q, state_d;
  logic [BW-1:0]        beat_q;
  logic signed [7:0]    sum_q;
  logic                 taken_q, conf_q;
  logic [31:0]          pc_q;
  logic [3*NUM_W-1:0]   weights_q;
  logic [NUM_W-1:0]     snap_q;
  logic [NUM_W-1:0]     ghr_q;

  logic                 accept;
  logic                 last_beat;
  logic signed [7:0]    acc_sum;
  logic                 acc_conf;
  logic signed [8:0]    acc_s9;
  logic [2:0]           w_v;
  logic signed [3:0]    term_v;
  logic signed [7:0]    bias_ext;

  assign accept    = req_valid & req_ready;
  assign last_beat = (beat_q == BW'(NUM_BEATS - 1));
  assign bias_ext  = {{6{req_bias[1]}}, req_bias};

  // Terms are widened to 4 bits before negation so that -(-4) stays +4.
  always_comb begin
    acc_sum = sum_q;
    w_v     = '0;
    term_v  = '0;
    for (int j = 0; j < W_PER_CYC; j++) begin
      w_v     = weights_q[3*(int'(beat_q)*W_PER_CYC + j) +: 3];
      term_v  = snap_q[int'(beat_q)*W_PER_CYC + j] ? $signed({w_v[2], w_v})
                                                   : -$signed({w_v[2], w_v});
      acc_sum = acc_sum + {{4{term_v[3]}}, term_v};
    end
    acc_s9   = {acc_sum[7], acc_sum};
    acc_conf = (acc_s9 > THETA_S) || (acc_s9 < -THETA_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (req_status == 2'b11) ? S_ACC : S_DONE;
      S_ACC:  if (last_beat) state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) && !flush;
    resp_valid = (state_q == S_DONE);
    dbg_state  = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= '0;
      sum_q     <= '0;
      taken_q   <= 1'b0;
      conf_q    <= 1'b0;
      pc_q      <= '0;
      weights_q <= '0;
      snap_q    <= '0;
    end else if (accept) begin
      pc_q      <= req_pc;
      weights_q <= req_weight;
      snap_q    <= ghr_q;
      beat_q    <= '0;
      if (req_status == 2'b11) begin
        sum_q <= bias_ext;
      end else begin
        sum_q   <= '0;
        taken_q <= (req_status == 2'b01);
        conf_q  <= (req_status != 2'b00);
      end
    end else if (state_q == S_ACC) begin
      sum_q  <= acc_sum;
      beat_q <= beat_q + BW'(1);
      if (last_beat) begin
        taken_q <= ~acc_sum[7];
        conf_q  <= acc_conf;
      end
    end
  end

  // History tracks fetch regardless of prediction state; repair beats speculation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ghr_q <= '0;
    else if (hist_restore) ghr_q <= hist_restore_val;
    else if (hist_valid)   ghr_q <= {ghr_q[NUM_W-2:0], hist_dir};
  end

  assign resp_sum       = sum_q;
  assign resp_taken     = taken_q;
  assign resp_confident = conf_q;
  assign resp_pc        = pc_q;
  assign ghr            = ghr_q;

endmodule
